// File: rtl/lock_sequencer_if.sv
// Handshake/feedback bundle between the lock sequencer (master) and the lock water/port stage (slave).
interface lock_sequencer_if #(
    parameter int W = 8
);
    logic         req_arrive;
    logic         req_depart;
    logic [W-1:0] lock_water;
    logic [W-1:0] outer_water;
    logic [W-1:0] inner_water;
    logic [1:0]   port_status;
    logic [5:0]   ctrl;
    logic         busy;
    logic         done;
    logic         fault;
    logic [3:0]   state;

    modport master (
        input  req_arrive, req_depart, lock_water, outer_water, inner_water, port_status,
        output ctrl, busy, done, fault, state
    );

    modport slave (
        output req_arrive, req_depart, lock_water, outer_water, inner_water, port_status,
        input  ctrl, busy, done, fault, state
    );
endinterface

// File: rtl/lock_sequencer.sv
// Sequences gondola passages through the canal lock; optional watchdog under LOCK_SEQ_TIMEOUT_EN.
// Request reaches CLOSE1 one edge after it is latched; waits on lock-stage feedback indefinitely unless the watchdog is built.
module lock_sequencer #(
    parameter int W              = 8,
    parameter int TRANSIT_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    lock_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLOSE1   = 4'd1,
        S_ADJ1     = 4'd2,
        S_OPEN_SRC = 4'd3,
        S_ENTER    = 4'd4,
        S_CLOSE2   = 4'd5,
        S_ADJ2     = 4'd6,
        S_OPEN_DST = 4'd7,
        S_EXIT     = 4'd8,
        S_FAULT    = 4'd9
    } state_t;

    // Direction encoding doubles as the src port / gondola flag bit index.
    localparam logic DIR_ARR = 1'b0;
    localparam logic DIR_DEP = 1'b1;

    localparam int TW = (TRANSIT_CYCLES > 1) ? $clog2(TRANSIT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TRANSIT_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic          pend_arr;
    logic          pend_dep;
    logic          last_dir;
    logic          dir;
    logic          win;
    logic          accept;
    logic [TW-1:0] tcnt;
    logic [1:0]    ports_r;
    logic [1:0]    ports_n;
    logic [1:0]    flags_r;
    logic [1:0]    flags_n;
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  src_lvl;
    logic [W-1:0]  dst_lvl;
    logic [W-1:0]  tgt;
    logic          adj;
    logic          pump_up;
    logic          pump_dn;

    assign src_lvl = (dir == DIR_DEP) ? bus.inner_water : bus.outer_water;
    assign dst_lvl = (dir == DIR_DEP) ? bus.outer_water : bus.inner_water;
    assign tgt     = (state == S_ADJ1) ? src_lvl : dst_lvl;
    assign adj     = (state == S_ADJ1) || (state == S_ADJ2);

    // Pump is combinational so it drops in the same cycle the level matches.
    assign pump_up = adj && (bus.lock_water < tgt);
    assign pump_dn = adj && (bus.lock_water > tgt);

    always_comb begin
        win = DIR_ARR;
        if (pend_arr && pend_dep) begin
            win = ~last_dir;
        end else if (pend_dep) begin
            win = DIR_DEP;
        end
    end

`ifdef LOCK_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WLAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] wcnt;
    logic           waiting;
    logic           fault_r;

    assign waiting = (state == S_CLOSE1) || (state == S_ADJ1) || (state == S_OPEN_SRC) ||
                     (state == S_CLOSE2) || (state == S_ADJ2) || (state == S_OPEN_DST);
`endif

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_arr || pend_dep) begin
                    state_n = S_CLOSE1;
                    accept  = 1'b1;
                end
            end
            S_CLOSE1:   if (bus.port_status == 2'b11) state_n = S_ADJ1;
            S_ADJ1:     if (bus.lock_water == tgt) state_n = S_OPEN_SRC;
            S_OPEN_SRC: if (!bus.port_status[dir]) state_n = S_ENTER;
            S_ENTER:    if (tcnt == TLAST) state_n = S_CLOSE2;
            S_CLOSE2:   if (bus.port_status == 2'b11) state_n = S_ADJ2;
            S_ADJ2:     if (bus.lock_water == tgt) state_n = S_OPEN_DST;
            S_OPEN_DST: if (!bus.port_status[~dir]) state_n = S_EXIT;
            S_EXIT:     if (tcnt == TLAST) state_n = S_IDLE;
            S_FAULT:    state_n = S_FAULT;
            default:    state_n = S_IDLE;
        endcase
`ifdef LOCK_SEQ_TIMEOUT_EN
        // Progress wins over the watchdog on the final cycle.
        if (waiting && (state_n == state) && (wcnt == WLAST)) begin
            state_n = S_FAULT;
        end
`endif
    end

    // Registered outputs are computed from the next state so they align with it.
    always_comb begin
        ports_n = 2'b11;
        flags_n = 2'b00;
        case (state_n)
            S_OPEN_SRC: ports_n[dir] = 1'b0;
            S_OPEN_DST: ports_n[~dir] = 1'b0;
            S_ENTER, S_EXIT: begin
                ports_n      = ports_r;
                flags_n[dir] = 1'b1;
            end
            default: ports_n = 2'b11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pend_arr <= 1'b0;
            pend_dep <= 1'b0;
            last_dir <= DIR_DEP;
            dir      <= DIR_ARR;
            tcnt     <= '0;
            ports_r  <= 2'b11;
            flags_r  <= 2'b00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            pend_arr <= (pend_arr && !(accept && win == DIR_ARR)) || bus.req_arrive;
            pend_dep <= (pend_dep && !(accept && win == DIR_DEP)) || bus.req_depart;
            if (accept) begin
                dir      <= win;
                last_dir <= win;
            end
            if ((state_n == state) && ((state == S_ENTER) || (state == S_EXIT))) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end
            ports_r <= ports_n;
            flags_r <= flags_n;
            busy_r  <= (state_n != S_IDLE);
            done_r  <= (state == S_EXIT) && (state_n == S_IDLE);
        end
    end

`ifdef LOCK_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt    <= '0;
            fault_r <= 1'b0;
        end else begin
            if (waiting && (state_n == state)) begin
                wcnt <= wcnt + WDW'(1);
            end else begin
                wcnt <= '0;
            end
            fault_r <= fault_r || (state_n == S_FAULT);
        end
    end

    assign bus.fault = fault_r;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.ctrl  = {pump_dn, pump_up, ports_r, flags_r};
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = state;

endmodule
